uart_tx_arbiter: RTL and testbench

- Shares the single UART transmitter between two byte-stream requesters: ch0 is the calculator result encoder, ch1 is the echo/error-message generator.
- Grants whole messages, delimited by a last flag, round-robin, and holds the grant until the message ends.
- Sequences each byte into the transmitter using a start/busy/done handshake, with a configurable inter-byte gap.
- A stall watchdog aborts any message whose requester stops supplying bytes.

---
 rtl/uart_tx_arbiter.sv | 179 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Purpose: round-robin, message-locked sharing of one UART transmitter between two byte streams.
// Latency: valid->grant 1 cycle, accept->tx_start 1 cycle, tx_done->next ready 1+GAP cycles.
// Backpressure: ready only for the granted channel in LOAD; tx_start held off while tx_busy is high.
module uart_tx_arbiter #(
    parameter int GAP  = 2,
    parameter int TO_W = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    input  logic       req0_last,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    input  logic       req1_last,
    output logic       req1_ready,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_busy,
    input  logic       tx_done,
    output logic [1:0] grant,
    output logic       busy,
    output logic       abort
);

    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_WAIT,
        S_GAP
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic            rr;        // 1: ch1 wins the next tie
    logic            last_q;
    logic [TO_W-1:0] wdog;
    logic [GW-1:0]   gap_cnt;

    logic            sel_valid;
    logic [7:0]      sel_data;
    logic            sel_last;
    logic            claim;     // IDLE picks an owner this cycle
    logic            pick1;     // owner being picked is ch1
    logic            take;      // byte accepted from the owner
    logic            finish;    // message over (last byte done or aborted)
    logic            start_gap;

    // The owner's stream; grant is zero outside a message so nothing is selected then.
    assign sel_valid = (grant[0] & req0_valid) | (grant[1] & req1_valid);
    assign sel_data  = grant[1] ? req1_data : req0_data;
    assign sel_last  = grant[1] ? req1_last : req0_last;
    assign busy      = (state != S_IDLE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode plus the handshake strobes that steer the datapath registers.
    always_comb begin
        state_nx   = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        tx_start   = 1'b0;
        abort      = 1'b0;
        claim      = 1'b0;
        pick1      = 1'b0;
        take       = 1'b0;
        finish     = 1'b0;
        start_gap  = 1'b0;
        case (state)
            S_IDLE: begin
                if (req0_valid | req1_valid) begin
                    claim    = 1'b1;
                    pick1    = req1_valid & (~req0_valid | rr);
                    state_nx = S_LOAD;
                end
            end
            S_LOAD: begin
                req0_ready = grant[0];
                req1_ready = grant[1];
                if (sel_valid) begin
                    take     = 1'b1;
                    state_nx = S_SEND;
                end else if (wdog == {TO_W{1'b1}}) begin
                    abort    = 1'b1;
                    finish   = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            S_SEND: begin
                if (!tx_busy) begin
                    tx_start = 1'b1;
                    state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                if (tx_done) begin
                    if (GAP > 0) begin
                        start_gap = 1'b1;
                        state_nx  = S_GAP;
                    end else if (last_q) begin
                        finish   = 1'b1;
                        state_nx = S_IDLE;
                    end else begin
                        state_nx = S_LOAD;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt == '0) begin
                    if (last_q) begin
                        finish   = 1'b1;
                        state_nx = S_IDLE;
                    end else begin
                        state_nx = S_LOAD;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Owner and fairness pointer: grant set on claim, cleared at message end; the pointer moves off the finished owner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant <= 2'b00;
            rr    <= 1'b0;
        end else if (claim) begin
            grant <= pick1 ? 2'b10 : 2'b01;
        end else if (finish) begin
            grant <= 2'b00;
            rr    <= grant[0];
        end
    end

    // Accepted byte and its last flag, held steady for the whole frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_data <= 8'h00;
            last_q  <= 1'b0;
        end else if (take) begin
            tx_data <= sel_data;
            last_q  <= sel_last;
        end
    end

    // Stall watchdog: counts only starved LOAD cycles, zero everywhere else.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog <= '0;
        end else if (state == S_LOAD && !take && !abort) begin
            wdog <= wdog + 1'b1;
        end else begin
            wdog <= '0;
        end
    end

    // Inter-byte gap countdown.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap_cnt <= '0;
        end else if (start_gap) begin
            gap_cnt <= GW'((GAP > 0) ? GAP - 1 : 0);
        end else if (state == S_GAP && gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter with GAP=2, TO_W=4: channel byte sources, a transmitter model,
// and a scoreboard of {grant, byte} in the order the transmitter should see them.
module tb_uart_tx_arbiter;
    localparam int GAP  = 2;
    localparam int TO_W = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid = 1'b0, req0_last = 1'b0, req0_ready;
    logic [7:0] req0_data = 8'h00;
    logic       req1_valid = 1'b0, req1_last = 1'b0, req1_ready;
    logic [7:0] req1_data = 8'h00;
    logic [7:0] tx_data;
    logic       tx_start, tx_busy, busy, abort;
    logic       tx_done = 1'b0;
    logic [1:0] grant;

    logic       tx_bsy = 1'b0;
    logic       busy_force = 1'b0;
    assign tx_busy = tx_bsy | busy_force;

    int compared = 0;
    int mismatched = 0;
    int nstart = 0;
    int ndone = 0;
    int epoch = 0;

    logic [8:0] q0[$];      // {last, data} waiting on ch0
    logic [8:0] q1[$];
    logic [9:0] exp_q[$];   // {grant, data} expected at each tx_start

    uart_tx_arbiter #(.GAP(GAP), .TO_W(TO_W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy), .tx_done(tx_done),
        .grant(grant), .busy(busy), .abort(abort)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

    // Byte sources: present the head of each queue, pop it after a handshake edge.
    initial begin
        logic hs0, hs1;
        logic [8:0] h;
        forever begin
            @(negedge clk);
            hs0 = req0_valid & req0_ready;
            hs1 = req1_valid & req1_ready;
            @(posedge clk);
            #1;
            if (hs0 && q0.size() > 0) void'(q0.pop_front());
            if (hs1 && q1.size() > 0) void'(q1.pop_front());
            if (q0.size() > 0) begin
                h = q0[0];
                req0_valid = 1'b1; req0_data = h[7:0]; req0_last = h[8];
            end else begin
                req0_valid = 1'b0; req0_data = 8'h00; req0_last = 1'b0;
            end
            if (q1.size() > 0) begin
                h = q1[0];
                req1_valid = 1'b1; req1_data = h[7:0]; req1_last = h[8];
            end else begin
                req1_valid = 1'b0; req1_data = 8'h00; req1_last = 1'b0;
            end
        end
    end

    // Transmitter model and scoreboard: tx_done 10 cycles after each start.
    initial begin
        logic [9:0] e;
        logic [7:0] d;
        int ep;
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1) begin
                nstart++;
                compared++;
                if (exp_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL tx_byte: unexpected start grant=%b data=%h", grant, tx_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({grant, tx_data} !== e) begin
                        mismatched++;
                        $display("FAIL tx_byte: got grant=%b data=%h want grant=%b data=%h",
                                 grant, tx_data, e[9:8], e[7:0]);
                    end
                end
                d  = tx_data;
                ep = epoch;
                @(posedge clk);
                #1 tx_bsy = 1'b1;
                @(negedge clk);
                compared++;
                if (tx_start !== 1'b0) begin
                    mismatched++;
                    $display("FAIL start_width: tx_start=%b one cycle after pulse, want 0", tx_start);
                end
                repeat (9) @(posedge clk);
                #1 tx_done = 1'b1;
                @(negedge clk);
                if (ep == epoch) begin
                    compared++;
                    if (tx_data !== d) begin
                        mismatched++;
                        $display("FAIL tx_hold: tx_data=%h at tx_done, want %h", tx_data, d);
                    end
                end
                @(posedge clk);
                #1;
                tx_done = 1'b0;
                tx_bsy  = 1'b0;
                ndone++;
            end
        end
    end

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        logic ok = 1'b0;
        while (!ok && n < budget) begin
            @(negedge clk);
            n++;
            ok = (busy === 1'b0) && (exp_q.size() == 0) && (q0.size() == 0) &&
                 (q1.size() == 0) && (tx_bsy == 1'b0);
        end
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL %s_idle: not idle after %0d cycles (busy=%b pending=%0d)", tag, n, busy, exp_q.size());
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        compared++; if (grant !== 2'b00) begin mismatched++; $display("FAIL reset_grant: got %b want 00", grant); end
        compared++; if (tx_data !== 8'h00) begin mismatched++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
        compared++; if (tx_start !== 1'b0) begin mismatched++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b want 0", busy); end
        compared++; if (abort !== 1'b0) begin mismatched++; $display("FAIL reset_abort: got %b want 0", abort); end
        compared++; if ({req0_ready, req1_ready} !== 2'b00) begin mismatched++; $display("FAIL reset_ready: got %b want 00", {req0_ready, req1_ready}); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_ch0();
        int s = nstart;
        int n = 0;
        q0.push_back({1'b0, 8'h31}); q0.push_back({1'b0, 8'h32}); q0.push_back({1'b1, 8'h33});
        exp_q.push_back({2'b01, 8'h31}); exp_q.push_back({2'b01, 8'h32}); exp_q.push_back({2'b01, 8'h33});
        do begin @(negedge clk); n++; end while (req0_valid !== 1'b1 && n < 20);
        @(negedge clk);
        compared++; if (grant !== 2'b01) begin mismatched++; $display("FAIL single_grant: got %b want 01", grant); end
        compared++; if (req0_ready !== 1'b1) begin mismatched++; $display("FAIL single_load_ready: got %b want 1", req0_ready); end
        wait_idle(200, "single");
        compared++; if (grant !== 2'b00) begin mismatched++; $display("FAIL single_end_grant: got %b want 00", grant); end
        compared++; if (nstart - s != 3) begin mismatched++; $display("FAIL single_starts: got %0d want 3", nstart - s); end
    endtask

    task automatic test_round_robin();
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        q0.push_back({1'b1, 8'hA0}); q0.push_back({1'b1, 8'hA1});
        q1.push_back({1'b1, 8'hB0});
        exp_q.push_back({2'b01, 8'hA0}); exp_q.push_back({2'b10, 8'hB0}); exp_q.push_back({2'b01, 8'hA1});
        wait_idle(300, "rr1");
        q0.push_back({1'b1, 8'hC0});
        q1.push_back({1'b1, 8'hD0});
        exp_q.push_back({2'b10, 8'hD0}); exp_q.push_back({2'b01, 8'hC0});
        wait_idle(300, "rr2");
    endtask

    task automatic test_packet_lock();
        int s = ndone;
        int n = 0;
        int bad = 0;
        for (int i = 0; i < 4; i++) begin
            q0.push_back({(i == 3), 8'h40 + 8'(i)});
            exp_q.push_back({2'b01, 8'h40 + 8'(i)});
        end
        do begin @(negedge clk); n++; end while (grant !== 2'b01 && n < 20);
        q1.push_back({1'b1, 8'hE0});
        exp_q.push_back({2'b10, 8'hE0});
        n = 0;
        while (grant === 2'b01 && n < 400) begin
            if (req1_ready !== 1'b0) bad++;
            @(negedge clk);
            n++;
        end
        compared++; if (bad != 0) begin mismatched++; $display("FAIL lock_ready1: req1_ready high %0d cycles, want 0", bad); end
        compared++; if (ndone - s != 4) begin mismatched++; $display("FAIL lock_release: grant left 01 after %0d done, want 4", ndone - s); end
        compared++; if (grant !== 2'b00) begin mismatched++; $display("FAIL lock_idle_grant: got %b want 00", grant); end
        @(negedge clk);
        compared++; if (grant !== 2'b10) begin mismatched++; $display("FAIL lock_next_grant: got %b want 10", grant); end
        wait_idle(200, "lock");
    endtask

    task automatic test_busy_gap();
        int n = 0;
        int bad = 0;
        busy_force = 1'b1;
        q0.push_back({1'b0, 8'h51}); q0.push_back({1'b1, 8'h52});
        exp_q.push_back({2'b01, 8'h51}); exp_q.push_back({2'b01, 8'h52});
        do begin @(negedge clk); n++; end while (!(req0_valid === 1'b1 && req0_ready === 1'b1) && n < 20);
        repeat (5) begin
            @(negedge clk);
            if (tx_start !== 1'b0) bad++;
        end
        compared++; if (bad != 0) begin mismatched++; $display("FAIL busy_hold: tx_start high %0d cycles while busy, want 0", bad); end
        @(posedge clk);
        #1 busy_force = 1'b0;
        @(negedge clk);
        compared++; if (tx_start !== 1'b1) begin mismatched++; $display("FAIL busy_release: tx_start=%b after busy drop, want 1", tx_start); end
        n = 0;
        do begin @(negedge clk); n++; end while (tx_done !== 1'b1 && n < 50);
        n = 0;
        do begin @(negedge clk); n++; end while (req0_ready !== 1'b1 && n < 20);
        compared++; if (n - 1 != GAP) begin mismatched++; $display("FAIL gap_cycles: got %0d idle cycles want %0d", n - 1, GAP); end
        wait_idle(200, "gap");
    endtask

    task automatic test_watchdog();
        int n = 0;
        int loads = 0;
        q0.push_back({1'b0, 8'h61});
        exp_q.push_back({2'b01, 8'h61});
        do begin @(negedge clk); n++; end while (grant !== 2'b01 && n < 20);
        q1.push_back({1'b1, 8'h71});
        exp_q.push_back({2'b10, 8'h71});
        n = 0;
        do begin @(negedge clk); n++; end while (tx_done !== 1'b1 && n < 50);
        n = 0;
        while (abort !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
            if (req0_ready === 1'b1 && abort !== 1'b1) loads++;
        end
        compared++; if (abort !== 1'b1) begin mismatched++; $display("FAIL wd_abort: abort=%b after %0d cycles, want 1", abort, n); end
        compared++; if (loads != 15) begin mismatched++; $display("FAIL wd_stall: %0d stalled LOAD cycles before abort, want 15", loads); end
        @(negedge clk);
        compared++; if ({grant, abort} !== 3'b000) begin mismatched++; $display("FAIL wd_after: grant=%b abort=%b want 00/0", grant, abort); end
        @(negedge clk);
        compared++; if (grant !== 2'b10) begin mismatched++; $display("FAIL wd_next_grant: got %b want 10", grant); end
        wait_idle(200, "wd");
    endtask

    task automatic test_reset_mid();
        int n = 0;
        q0.push_back({1'b0, 8'h81}); q0.push_back({1'b1, 8'h82});
        exp_q.push_back({2'b01, 8'h81});
        do begin @(negedge clk); n++; end while (tx_bsy !== 1'b1 && n < 30);
        #2;
        epoch++;
        rst = 1'b1;
        #1;
        compared++; if ({grant, tx_start, busy} !== 4'b0000) begin mismatched++; $display("FAIL rstmid_async: grant=%b tx_start=%b busy=%b want 00/0/0", grant, tx_start, busy); end
        q0.delete();
        repeat (2) @(negedge clk);
        compared++; if (req0_ready !== 1'b0) begin mismatched++; $display("FAIL rstmid_ready: got %b want 0", req0_ready); end
        rst = 1'b0;
        q1.push_back({1'b0, 8'h91}); q1.push_back({1'b1, 8'h92});
        exp_q.push_back({2'b10, 8'h91}); exp_q.push_back({2'b10, 8'h92});
        wait_idle(300, "rstmid");
    endtask

    initial begin
        test_reset();
        test_single_ch0();
        test_round_robin();
        test_packet_lock();
        test_busy_gap();
        test_watchdog();
        test_reset_mid();
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL leftover: %0d expected bytes never transmitted, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
